// File: rtl/imem_pkg.sv
// imem_pkg: shared FSM states, constants and address checks
// for the instruction memory responder.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_t;

  localparam int unsigned IMEM_DEPTH = 1024;
  localparam logic [31:0] IMEM_NOP   = 32'h00000013;

  // Misaligned or past the end of the array.
  function automatic logic addr_bad(
    input logic [31:0] a,
    input int unsigned depth
  );
    return (a[1:0] != 2'b00) ||
           ({2'b00, a[31:2]} >= depth);
  endfunction

  function automatic logic idx_ok(
    input logic [31:0] a,
    input int unsigned depth
  );
    return {2'b00, a[31:2]} < depth;
  endfunction

endpackage

// File: rtl/imem_array.sv
// imem_array: word-wide ROM storage, one synchronous read port
// and one write port; a same-edge write never disturbs the read.
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = IMEM_DEPTH,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/imem_responder.sv
// imem_responder: instruction fetch responder with boot-load port.
// Define IMEM_WAIT_STATE_EN to add WAIT_CYCLES wait states per fetch.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH       = IMEM_DEPTH,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] NOP_INST    = IMEM_NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic        flush,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        resp_valid,
  output logic [31:0] resp_inst,
  output logic [31:0] resp_addr,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned AW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;

  imem_state_t state;
  logic [31:0] addr_q;
  logic        err_q;
  logic        valid_q;
  logic [31:0] rd_data;
  logic        rd_en;
  logic [AW-1:0] rd_addr;
  logic        wr_en;
  logic        req_bad;
  logic        take;
  logic        wait_done;
  logic        show;
  logic        unused_bits;

`ifdef IMEM_WAIT_STATE_EN
  localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
  localparam int unsigned CW =
    (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [CW-1:0] cnt;

  assign wait_done = (state == WAIT) && (cnt == '0) &&
                     !flush && !reset;
  assign busy = (state == WAIT);
`else
  localparam bit HAS_WAIT = 1'b0;
  localparam int unsigned unused_wait = WAIT_CYCLES;

  assign wait_done = 1'b0;
  assign busy = 1'b0;
`endif

  assign req_bad = addr_bad(req_addr, DEPTH);
  assign take = req_valid && !flush && !reset &&
                (state != WAIT);

  // The array read happens on the edge that enters RESP.
  assign rd_en = (take && !HAS_WAIT && !req_bad) ||
                 (wait_done && !err_q);
  assign rd_addr = wait_done ? addr_q[AW+1:2]
                             : req_addr[AW+1:2];

  assign wr_en = ld_en && !reset && idx_ok(ld_addr, DEPTH);
  assign unused_bits = ^ld_addr[1:0];

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (ld_addr[AW+1:2]),
    .wr_data (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef IMEM_WAIT_STATE_EN
      cnt     <= '0;
`endif
    end else if (flush) begin
      state   <= IDLE;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state)
        IDLE, RESP: begin
          if (take) begin
            addr_q <= req_addr;
            err_q  <= req_bad;
`ifdef IMEM_WAIT_STATE_EN
            if (HAS_WAIT) begin
              state <= WAIT;
              cnt   <= CW'(WAIT_CYCLES - 1);
            end else begin
              state   <= RESP;
              valid_q <= 1'b1;
            end
`else
            state   <= RESP;
            valid_q <= 1'b1;
`endif
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
`ifdef IMEM_WAIT_STATE_EN
          if (cnt == '0) begin
            state   <= RESP;
            valid_q <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flush or reset kills a response already on the wire.
  assign show       = valid_q && !flush && !reset;
  assign resp_valid = show;
  assign resp_err   = show && err_q;
  assign resp_inst  = (show && !err_q) ? rd_data : NOP_INST;
  assign resp_addr  = addr_q;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: random fetch/flush/reset/load traffic checked
// against a transaction-level model, plus literal directed checks.
module tb_imem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WC    = 2;
  localparam logic [31:0] NOP   = 32'h00000013;
`ifdef IMEM_WAIT_STATE_EN
  localparam int unsigned W = WC;
`else
  localparam int unsigned W = 0;
`endif

  localparam logic [31:0] W0 = 32'h00A00093;
  localparam logic [31:0] W1 = 32'h00200113;
  localparam logic [31:0] W2 = 32'h002081B3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic [31:0] resp_addr;
  logic        resp_err;
  logic        busy;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  imem_responder #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WC),
    .NOP_INST    (NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .flush      (flush),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .resp_valid (resp_valid),
    .resp_inst  (resp_inst),
    .resp_addr  (resp_addr),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: one outstanding fetch; it is busy for W cycles,
  // then visible for one cycle. The word is sampled from the
  // memory image as it stood before the load on the read edge.
  logic [31:0] mem_m [DEPTH];
  bit          pend = 1'b0;
  int          rem = 0;
  logic [31:0] p_addr = '0;
  logic [31:0] p_inst = '0;
  bit          p_err = 1'b0;
  bit          acc;

  always @(posedge clk) begin
    if (reset) begin
      pend = 1'b0;
      p_addr = '0;
    end else if (flush) begin
      pend = 1'b0;
    end else begin
      acc = req_valid && !(pend && rem > 0);
      if (acc) begin
        pend = 1'b1;
        rem = W;
        p_addr = req_addr;
        p_err = (req_addr % 4 != 0) || (req_addr / 4 >= DEPTH);
        if (W == 0 && !p_err) p_inst = mem_m[req_addr / 4];
      end else if (pend && rem > 0) begin
        rem--;
        if (rem == 0 && !p_err) p_inst = mem_m[p_addr / 4];
      end else begin
        pend = 1'b0;
      end
    end
    if (!reset && ld_en && ld_addr / 4 < DEPTH)
      mem_m[ld_addr / 4] = ld_data;
  end

  bit ev;
  always @(negedge clk) begin
    if (chk_en) begin
      ev = pend && rem == 0 && !reset && !flush;
      check("m_resp_valid", resp_valid, ev);
      check("m_resp_inst", resp_inst,
            ev ? (p_err ? NOP : p_inst) : NOP);
      check("m_resp_err", resp_err, ev && p_err);
      if (ev) check("m_resp_addr", resp_addr, p_addr);
      check("m_busy", busy, pend && rem > 0);
    end
  end

  task automatic step(input bit rv, input logic [31:0] a,
                      input bit fl, input bit rs);
    @(posedge clk);
    #1;
    req_valid = rv;
    req_addr = a;
    flush = fl;
    reset = rs;
    ld_en = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick_addr();
    int unsigned k;
    logic [31:0] a;
    k = $urandom_range(0, 9);
    if (k < 4) a = 4 * $urandom_range(0, 15);
    else if (k < 7) a = 4 * $urandom_range(0, DEPTH - 1);
    else if (k == 7)
      a = 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
    else if (k == 8) a = 4 * DEPTH + 4 * $urandom_range(0, 7);
    else a = $urandom;
    return a;
  endfunction

  initial begin
    step(0, 0, 0, 1);
    chk_en = 1'b1;
    step(0, 0, 0, 1);
    check("rst_valid", resp_valid, 0);
    check("rst_inst", resp_inst, NOP);
    check("rst_addr", resp_addr, 0);
    check("rst_err", resp_err, 0);
    check("rst_busy", busy, 0);

    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk);
      #1;
      reset = 1'b0;
      ld_en = 1'b1;
      ld_addr = 4 * i;
      ld_data = (i == 0) ? W0 : (i == 1) ? W1 :
                (i == 2) ? W2 : $urandom;
    end

    step(1, 0, 0, 0);
    check("first_idle", resp_valid, 0);
    repeat (W) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("first_valid", resp_valid, 1);
    check("first_inst", resp_inst, W0);
    check("first_addr", resp_addr, 0);
    check("first_err", resp_err, 0);

    step(1, 2, 0, 0);
    repeat (W) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("mis_valid", resp_valid, 1);
    check("mis_err", resp_err, 1);
    check("mis_inst", resp_inst, NOP);
    check("mis_addr", resp_addr, 2);

    step(1, 4 * DEPTH, 0, 0);
    repeat (W) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("oor_valid", resp_valid, 1);
    check("oor_err", resp_err, 1);
    check("oor_inst", resp_inst, NOP);

`ifdef IMEM_WAIT_STATE_EN
    step(1, 8, 0, 0);
    check("w_busy0", busy, 0);
    step(0, 0, 0, 0);
    check("w_busy1", busy, 1);
    check("w_valid1", resp_valid, 0);
    step(0, 0, 0, 0);
    check("w_busy2", busy, 1);
    step(0, 0, 0, 0);
    check("w_valid3", resp_valid, 1);
    check("w_inst3", resp_inst, W2);
    check("w_busy3", busy, 0);

    step(1, 4, 0, 0);
    step(0, 0, 1, 0);
    check("wf_busy", busy, 1);
    check("wf_valid", resp_valid, 0);
    step(0, 0, 0, 0);
    check("wf_busy_drop", busy, 0);
    step(0, 0, 0, 0);
    check("wf_no_resp", resp_valid, 0);

    step(1, 8, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("wr_busy", busy, 0);
    check("wr_valid", resp_valid, 0);
    check("wr_inst", resp_inst, NOP);
    check("wr_addr", resp_addr, 0);
    check("wr_err", resp_err, 0);
    step(1, 8, 0, 0);
    repeat (WC) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("wr_refetch", resp_inst, W2);
`else
    step(1, 0, 0, 0);
    step(1, 4, 0, 0);
    check("b2b_v0", resp_valid, 1);
    check("b2b_i0", resp_inst, W0);
    step(1, 8, 0, 0);
    check("b2b_v1", resp_valid, 1);
    check("b2b_i1", resp_inst, W1);
    check("b2b_a1", resp_addr, 4);
    step(0, 0, 0, 0);
    check("b2b_v2", resp_valid, 1);
    check("b2b_i2", resp_inst, W2);
    check("b2b_a2", resp_addr, 8);
    step(0, 0, 0, 0);
    check("b2b_end", resp_valid, 0);
    check("b2b_nop", resp_inst, NOP);

    step(1, 4, 0, 0);
    step(0, 0, 1, 0);
    check("fl_valid", resp_valid, 0);
    check("fl_inst", resp_inst, NOP);
    step(0, 0, 0, 0);
    check("fl_after", resp_valid, 0);

    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    check("rr_valid", resp_valid, 0);
    step(0, 0, 0, 0);
    check("rr_idle", resp_valid, 0);
    check("rr_addr", resp_addr, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check("rr_refetch", resp_inst, W0);
`endif

    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      #1;
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr = pick_addr();
      flush = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 63) == 0);
      ld_en = ($urandom_range(0, 4) == 0);
      ld_addr = pick_addr();
      ld_data = $urandom;
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
